// File: rtl/and_1.sv
`default_nettype none
// ============================================================================
// Module   : and_1
// Brief    : Bitwise AND gate with a registered copy, all-high edge flags and
//            a saturating count of all-high cycles.
// Revision : 1.0 - initial release
// ============================================================================
module and_1 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             clr,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_r,
    output logic             all_hi,
    output logic             any_hi,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] hi_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_r_d, q_r_q;
    logic             prev_d, prev_q;
    logic             rise_d, rise_q;
    logic             fall_d, fall_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Gate path stays purely combinational so it works without a clock.
    always_comb begin
        Q      = A & B;
        all_hi = &Q;
        any_hi = |Q;
    end

    always_comb begin
        q_r_d  = Q;
        prev_d = all_hi;
        rise_d = all_hi & ~prev_q;
        fall_d = ~all_hi & prev_q;
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = C_CNT_ZERO;
        end else if (all_hi && (cnt_q != C_CNT_MAX)) begin
            cnt_d = cnt_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r_q  <= {WIDTH{1'b0}};
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            cnt_q  <= C_CNT_ZERO;
        end else begin
            q_r_q  <= q_r_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    assign Q_r    = q_r_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign hi_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_and_1.sv
`default_nettype none
// ============================================================================
// Module   : tb_and_1
// Brief    : Self-checking bench for and_1 (WIDTH=1/CNT_W=2 and WIDTH=4/CNT_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_and_1;

    localparam int CW1 = 2;
    localparam int CW4 = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0;
    logic [3:0] a4 = 4'h0, b4 = 4'h0;

    logic       q1, qr1, all1, any1, rise1, fall1;
    logic [CW1-1:0] cnt1;
    logic [3:0] q4, qr4;
    logic       all4, any4, rise4, fall4;
    logic [CW4-1:0] cnt4;

    int checks   = 0;
    int failures = 0;

    // Reference state, index 0 = 1-bit instance, index 1 = 4-bit instance
    int m_qr[2], m_prev[2], m_rise[2], m_fall[2], m_cnt[2];

    always #5 clk = ~clk;

    and_1 #(.WIDTH(1), .CNT_W(CW1)) u_dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .clr(clr),
        .Q(q1), .Q_r(qr1), .all_hi(all1), .any_hi(any1),
        .rise(rise1), .fall(fall1), .hi_cnt(cnt1)
    );

    and_1 #(.WIDTH(4), .CNT_W(CW4)) u_dut4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .clr(clr),
        .Q(q4), .Q_r(qr4), .all_hi(all4), .any_hi(any4),
        .rise(rise4), .fall(fall4), .hi_cnt(cnt4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural rules applied at a rising edge with the inputs then present.
    task automatic model_edge(input int idx, input int a, input int b, input int width,
                              input int cw, input int r, input int c);
        int q, all_v, cmax;
        q     = a & b;
        all_v = (q == (1 << width) - 1) ? 1 : 0;
        cmax  = (1 << cw) - 1;
        if (r != 0) begin
            m_qr[idx] = 0; m_prev[idx] = 0; m_rise[idx] = 0; m_fall[idx] = 0; m_cnt[idx] = 0;
        end else begin
            m_qr[idx]   = q;
            m_rise[idx] = (all_v == 1 && m_prev[idx] == 0) ? 1 : 0;
            m_fall[idx] = (all_v == 0 && m_prev[idx] == 1) ? 1 : 0;
            m_prev[idx] = all_v;
            if (c != 0)          m_cnt[idx] = 0;
            else if (all_v == 1) m_cnt[idx] = (m_cnt[idx] < cmax) ? m_cnt[idx] + 1 : cmax;
        end
    endtask

    task automatic check_comb();
        int q1e, q4e;
        q1e = int'(a1) & int'(b1);
        q4e = int'(a4) & int'(b4);
        check("q1",   32'(q1),   32'(q1e));
        check("all1", 32'(all1), 32'(q1e));
        check("any1", 32'(any1), 32'(q1e));
        check("q4",   32'(q4),   32'(q4e));
        check("all4", 32'(all4), (q4e == 15) ? 32'd1 : 32'd0);
        check("any4", 32'(any4), (q4e != 0)  ? 32'd1 : 32'd0);
    endtask

    task automatic check_regs();
        check("qr1",   32'(qr1),   32'(m_qr[0]));
        check("rise1", 32'(rise1), 32'(m_rise[0]));
        check("fall1", 32'(fall1), 32'(m_fall[0]));
        check("cnt1",  32'(cnt1),  32'(m_cnt[0]));
        check("qr4",   32'(qr4),   32'(m_qr[1]));
        check("rise4", 32'(rise4), 32'(m_rise[1]));
        check("fall4", 32'(fall4), 32'(m_fall[1]));
        check("cnt4",  32'(cnt4),  32'(m_cnt[1]));
    endtask

    // One clock: model sees the edge, registered outputs checked at the negedge.
    task automatic cycle();
        @(posedge clk);
        model_edge(0, int'(a1), int'(b1), 1, CW1, int'(rst), int'(clr));
        model_edge(1, int'(a4), int'(b4), 4, CW4, int'(rst), int'(clr));
        @(negedge clk);
        check_regs();
    endtask

    task automatic drive(input logic na1, input logic nb1, input logic [3:0] na4,
                         input logic [3:0] nb4, input logic nr, input logic nc);
        a1 = na1; b1 = nb1; a4 = na4; b4 = nb4; rst = nr; clr = nc;
        #1;
        check_comb();
    endtask

    initial begin
        logic [3:0] tt_a, tt_b, tt_q;
        int sat_exp[6];
        tt_a = 4'b1010; tt_b = 4'b1100; tt_q = 4'b1000;
        sat_exp = '{1, 2, 3, 3, 3, 3};
        for (int i = 0; i < 2; i++) begin
            m_qr[i] = 0; m_prev[i] = 0; m_rise[i] = 0; m_fall[i] = 0; m_cnt[i] = 0;
        end

        // Unclocked truth table (registers are not examined here)
        for (int i = 0; i < 4; i++) begin
            a1 = tt_a[i]; b1 = tt_b[i];
            #10;
            check("tt_q", 32'(q1), 32'(tt_q[i]));
        end

        // Reset for two cycles
        @(negedge clk);
        drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        cycle(); cycle();
        check("rst_qr1", 32'(qr1), 32'd0);
        check("rst_cnt1", 32'(cnt1), 32'd0);

        // Registered path and edge sequence 0,1,1,0
        drive(1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0);
        check("qr1_pre", 32'(qr1), 32'd0);
        cycle();
        check("qr1_load", 32'(qr1), 32'd1);
        check("rise1_pulse", 32'(rise1), 32'd1);
        cycle();
        check("rise1_once", 32'(rise1), 32'd0);
        drive(1'b1, 1'b0, 4'hF, 4'h7, 1'b0, 1'b0);
        cycle();
        check("qr1_drop", 32'(qr1), 32'd0);
        check("fall1_pulse", 32'(fall1), 32'd1);
        cycle();
        check("fall1_once", 32'(fall1), 32'd0);

        // Saturation on the 2-bit counter
        drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("sat_cnt1", 32'(cnt1), 32'(sat_exp[i]));
        end
        drive(1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 1'b1);
        cycle();
        check("clr_prio", 32'(cnt1), 32'd0);

        // Reset mid-count
        drive(1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0);
        cycle(); cycle();
        check("mid_cnt1", 32'(cnt1), 32'd2);
        drive(1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b0);
        cycle();
        check("mid_rst_cnt", 32'(cnt1), 32'd0);
        check("mid_rst_qr", 32'(qr1), 32'd0);
        check("mid_rst_fall", 32'(fall1), 32'd0);
        check("mid_rst_q", 32'(q1), 32'd1);
        drive(1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0);
        cycle();
        check("post_rst_rise", 32'(rise1), 32'd1);

        // 4-bit directed patterns
        drive(1'b0, 1'b0, 4'b1100, 4'b1010, 1'b0, 1'b0);
        check("w4_q", 32'(q4), 32'h8);
        check("w4_any", 32'(any4), 32'd1);
        check("w4_all", 32'(all4), 32'd0);
        drive(1'b0, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0);
        check("w4_allF", 32'(all4), 32'd1);
        cycle();

        // Randomized traffic, biased toward all-high so edges and counts occur
        for (int n = 0; n < 400; n++) begin
            logic na1, nb1, nr, nc;
            logic [3:0] na4, nb4;
            na1 = ($urandom_range(3) != 0);
            nb1 = ($urandom_range(3) != 0);
            na4 = ($urandom_range(1) != 0) ? 4'hF : 4'($urandom);
            nb4 = ($urandom_range(1) != 0) ? 4'hF : 4'($urandom);
            nr  = ($urandom_range(31) == 0);
            nc  = ($urandom_range(7) == 0);
            drive(na1, nb1, na4, nb4, nr, nc);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
